// File: rtl/pa_spsram_ctrl_pkg.sv
// pa_spsram_ctrl_pkg: shared state encoding and default geometry for the
// 32x4 single-port SRAM controller.
package pa_spsram_ctrl_pkg;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 4;
    localparam logic [1:0] ST_INIT = 2'b01;
    localparam logic [1:0] ST_IDLE = 2'b10;
endpackage

// File: rtl/pa_spsram_rsp_buf.sv
// pa_spsram_rsp_buf: read-pending flag plus single-entry response register.
// A stalled response freezes both the pending flag and the captured data.
module pa_spsram_rsp_buf
    import pa_spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_acc_i,
    input  logic                  rsp_rdy_i,
    input  logic [DATA_WIDTH-1:0] sram_q_i,
    output logic                  rd_pend_o,
    output logic                  rsp_vld_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o
);
    logic                  rd_pend_q, rd_pend_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  stall;

    assign stall      = rsp_vld_q && !rsp_rdy_i;
    assign rd_pend_d  = stall ? rd_pend_q : rd_acc_i;
    assign rsp_vld_d  = stall || rd_pend_q;
    // The SRAM is not accessed while stalled, so Q is still valid on release.
    assign rsp_data_d = (rd_pend_q && !stall) ? sram_q_i : rsp_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pend_q  <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rd_pend_o  = rd_pend_q;
    assign rsp_vld_o  = rsp_vld_q;
    assign rsp_data_o = rsp_data_q;
endmodule

// File: rtl/pa_spsram_32x4_ctrl.sv
// pa_spsram_32x4_ctrl: valid/ready initiator for the 32x4 single-port SRAM,
// with an init sweep after reset or on request and a backpressured read path.
module pa_spsram_32x4_ctrl
    import pa_spsram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  init_req,
    output logic                  init_busy,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d, a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  rd_pend, idle, in_init, init_start, acc, wr_acc;

    assign idle       = !cpurst && state_q == ST_IDLE;
    assign in_init    = !cpurst && state_q == ST_INIT;
    assign init_start = idle && init_req && !rd_pend;
    assign req_rdy    = idle && !init_start && !(rsp_vld && !rsp_rdy);
    assign acc        = req_vld && req_rdy;
    assign wr_acc     = acc && req_wr;
    assign init_busy  = cpurst || state_q == ST_INIT;

    // Unused encodings fall back into the sweep.
    assign state_d    = (state_q == ST_INIT) ? ((&init_cnt_q) ? ST_IDLE : ST_INIT) :
                        (state_q == ST_IDLE && !init_start) ? ST_IDLE : ST_INIT;
    assign init_cnt_d = (state_q == ST_INIT) ? init_cnt_q + 1'b1 : '0;

    assign sram_cen  = !(in_init || acc);
    assign sram_gwen = !(in_init || wr_acc);
    assign sram_wen  = in_init ? '0 : wr_acc ? ~req_wmask : '1;
    assign sram_a    = cpurst ? '0 : in_init ? init_cnt_q : acc ? req_addr : a_q;
    assign sram_d    = cpurst ? '0 : in_init ? INIT_VAL : wr_acc ? req_wdata : d_q;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            a_q        <= '0;
            d_q        <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            a_q        <= sram_a;
            d_q        <= sram_d;
        end
    end

    pa_spsram_rsp_buf #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_buf (
        .clk_i      (forever_cpuclk),
        .rst_i      (cpurst),
        .rd_acc_i   (acc && !req_wr),
        .rsp_rdy_i  (rsp_rdy),
        .sram_q_i   (sram_q),
        .rd_pend_o  (rd_pend),
        .rsp_vld_o  (rsp_vld),
        .rsp_data_o (rsp_data)
    );
endmodule

// File: tb/tb_pa_spsram_32x4_ctrl.sv
// tb_pa_spsram_32x4_ctrl: directed bench with an SRAM pin model and a
// reference memory/response scoreboard checked every cycle.
module tb_pa_spsram_32x4_ctrl;
    logic       clk = 1'b0;
    logic       cpurst = 1'b1, init_req = 1'b0, init_busy;
    logic       req_vld = 1'b0, req_rdy, req_wr = 1'b0;
    logic [4:0] req_addr = '0;
    logic [3:0] req_wdata = '0, req_wmask = '0;
    logic       rsp_vld, rsp_rdy = 1'b1;
    logic [3:0] rsp_data;
    logic       sram_cen, sram_gwen;
    logic [3:0] sram_wen, sram_d, sram_q = '0;
    logic [4:0] sram_a;

    int errors = 0, checks = 0;
    logic [3:0] mem [32];
    logic [3:0] ref_mem [32];
    logic [3:0] exp_q [$];
    logic       hold_v = 1'b0;
    logic [3:0] hold_data = '0;

    always #5 clk = ~clk;

    pa_spsram_32x4_ctrl dut (
        .forever_cpuclk(clk), .cpurst(cpurst), .init_req(init_req), .init_busy(init_busy),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_data(rsp_data), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    initial for (int i = 0; i < 32; i++) mem[i] = 4'hF;

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents and in-order expected read data.
    always @(negedge clk) begin
        if (cpurst || init_req) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = 4'h0;
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (rsp_vld && rsp_rdy) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", {31'd0, rsp_vld}, 32'd0);
                else chk("rsp_data", {28'd0, rsp_data}, {28'd0, exp_q.pop_front()});
            end
            if (req_vld && req_rdy) begin
                if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                else exp_q.push_back(ref_mem[req_addr]);
            end
            if (hold_v && rsp_vld) chk("stall_hold", {28'd0, rsp_data}, {28'd0, hold_data});
            if (rsp_vld && !rsp_rdy) chk("stall_pins", {30'd0, req_rdy, sram_cen}, 32'd1);
            if (init_busy) chk("busy_rdy", {31'd0, req_rdy}, 32'd0);
            hold_v = rsp_vld && !rsp_rdy;
            hold_data = rsp_data;
        end
    end

    task automatic sweep_check();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("sweep", {16'd0, init_busy, sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                {16'd0, 1'b1, 1'b0, 1'b0, 4'h0, 5'(k), 4'h0});
        end
        @(negedge clk);
        chk("sweep_done", {30'd0, init_busy, req_rdy}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic wr, input logic [4:0] a, input logic [3:0] d, input logic [3:0] m);
        int n = 0;
        req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
        @(negedge clk);
        while (!req_rdy && n < 50) begin @(negedge clk); n++; end
        chk("req_accept", {31'd0, req_rdy}, 32'd1);
        if (wr) chk("wr_pins", {17'd0, sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                    {17'd0, 1'b0, 1'b0, ~m, a, d});
        else chk("rd_pins", {21'd0, sram_cen, sram_gwen, sram_wen, sram_a},
                 {21'd0, 1'b0, 1'b1, 4'hF, a});
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic read_check(input logic [4:0] a, input logic [3:0] e, input string name);
        issue(1'b0, a, 4'h0, 4'h0);
        @(negedge clk);
        chk({name, "_t1"}, {31'd0, rsp_vld}, 32'd0);
        @(negedge clk);
        chk(name, {27'd0, rsp_vld, rsp_data}, {27'd0, 1'b1, e});
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pins", {12'd0, init_busy, req_rdy, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, rsp_vld, rsp_data},
            {12'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 5'd0, 4'h0, 1'b0, 4'h0});
        @(posedge clk); #1;
        cpurst = 1'b0;
        sweep_check();
        read_check(5'd5, 4'h0, "init_read5");

        issue(1'b1, 5'd3, 4'hA, 4'hF);
        read_check(5'd3, 4'hA, "read3_A");
        issue(1'b1, 5'd3, 4'h5, 4'b0011);
        read_check(5'd3, 4'b1001, "masked_write");
        issue(1'b1, 5'd3, 4'hF, 4'h0);
        read_check(5'd3, 4'b1001, "mask_zero");

        issue(1'b1, 5'd0, 4'h1, 4'hF);
        issue(1'b1, 5'd1, 4'h2, 4'hF);
        issue(1'b1, 5'd2, 4'h3, 4'hF);
        fork
            begin
                req_vld = 1'b1; req_wr = 1'b0; req_addr = 5'd0;
                @(posedge clk); #1 req_addr = 5'd1;
                @(posedge clk); #1 req_addr = 5'd2;
                @(posedge clk); #1 req_vld = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("b2b", {27'd0, rsp_vld, rsp_data}, {27'd0, 1'b1, 4'(k + 1)});
                end
            end
        join
        @(posedge clk); #1;

        rsp_rdy = 1'b0;
        fork
            begin
                req_vld = 1'b1; req_wr = 1'b0; req_addr = 5'd0;
                @(posedge clk); #1 req_addr = 5'd1;
                @(posedge clk); #1 req_vld = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_stall", {25'd0, rsp_vld, rsp_data, req_rdy, sram_cen},
                        {25'd0, 1'b1, 4'h1, 1'b0, 1'b1});
                end
                @(posedge clk); #1 rsp_rdy = 1'b1;
                @(negedge clk);
                chk("bp_first", {27'd0, rsp_vld, rsp_data}, {27'd0, 1'b1, 4'h1});
                @(negedge clk);
                chk("bp_second", {27'd0, rsp_vld, rsp_data}, {27'd0, 1'b1, 4'h2});
                @(negedge clk);
                chk("bp_empty", {31'd0, rsp_vld}, 32'd0);
            end
        join
        @(posedge clk); #1;

        init_req = 1'b1;
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 5'd7; req_wdata = 4'hF; req_wmask = 4'hF;
        @(negedge clk);
        chk("init_prio", {29'd0, req_rdy, sram_cen, init_busy}, 32'd2);
        @(posedge clk); #1 init_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("sweep2", {26'd0, init_busy, sram_a}, {26'd0, 1'b1, 5'(k)});
        end
        @(posedge clk); #1 cpurst = 1'b1;
        @(negedge clk);
        chk("mid_reset", {23'd0, init_busy, req_rdy, sram_cen, sram_a, rsp_vld}, {23'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0});
        @(posedge clk); #1 cpurst = 1'b0;
        sweep_check();
        req_vld = 1'b0;
        read_check(5'd7, 4'hF, "held_write");
        read_check(5'd3, 4'h0, "reinit_read3");

        chk("drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1);
    end
endmodule
